regfile_xcpt_stack: RTL and testbench

//  Parametrised integer register file with NUM_RD read ports and one write port.
//  It also holds the exception-state registers (rm0 = PC, rm1 = address, rm2 = type)
//  and the privilege mode. Exception state is kept on a stack of depth XCPT_DEPTH,
//  so nested exceptions and iret unwinding are supported. The block sits in decode
//  (reads) and writeback (writes, xcpt, iret) of the custom core.

---
 rtl/regfile_xcpt_stack.sv | 144 ++++++++++++++
 tb/tb_regfile_xcpt_stack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_xcpt_stack.sv
// regfile_xcpt_stack: integer register file (NUM_RD read ports, one write port)
// plus a stack of exception-state entries {pc, addr, type, prev priv} and the
// current privilege mode.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_xcpt_stack #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned XCPT_DEPTH  = 4,
    parameter int unsigned XCPT_TYPE_W = 3,
    parameter int unsigned DEPTH_W     = $clog2(XCPT_DEPTH + 1)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_xcpt_valid,
    input  logic [XCPT_TYPE_W-1:0]   i_xcpt_type,
    input  logic [31:0]              i_xcpt_pc,
    input  logic [31:0]              i_xcpt_addr,
    input  logic                     i_iret_instr,
    output logic [31:0]              o_rm0_data,
    output logic [31:0]              o_rm1_data,
    output logic [XCPT_TYPE_W-1:0]   o_rm2_data,
    output logic                     o_priv_mode,
    output logic [DEPTH_W-1:0]       o_xcpt_depth,
    output logic                     o_xcpt_overflow
);

    // Storage is sized to the full address space so out-of-range reads see a
    // register that is never written (always 0).
    localparam int unsigned REG_SLOTS = 1 << ADDR_W;
    localparam int unsigned IDX_W     = (XCPT_DEPTH > 1) ? $clog2(XCPT_DEPTH) : 1;
    localparam int unsigned STK_SLOTS = 1 << IDX_W;

    logic [DATA_W-1:0]      r_regs     [REG_SLOTS];
    logic [31:0]            r_stk_pc   [STK_SLOTS];
    logic [31:0]            r_stk_addr [STK_SLOTS];
    logic [XCPT_TYPE_W-1:0] r_stk_type [STK_SLOTS];
    logic                   r_stk_priv [STK_SLOTS];
    logic [DEPTH_W-1:0]     r_depth;
    logic                   r_priv;
    logic                   r_overflow;

    logic                   w_wr_ok;
    logic                   w_full;
    logic                   w_empty;
    logic [IDX_W-1:0]       w_push_idx;
    logic [IDX_W-1:0]       w_top_idx;

    // Address range check only exists when NUM_REGS leaves holes in the space.
    generate
        if (NUM_REGS < REG_SLOTS) begin : g_range_chk
            assign w_wr_ok = ({1'b0, i_wr_addr} < (ADDR_W + 1)'(NUM_REGS));
        end else begin : g_no_range_chk
            assign w_wr_ok = 1'b1;
        end
    endgenerate

    assign w_full     = (r_depth == DEPTH_W'(XCPT_DEPTH));
    assign w_empty    = (r_depth == '0);
    // A push into a full stack overwrites the top entry.
    assign w_push_idx = w_full ? IDX_W'(XCPT_DEPTH - 1) : IDX_W'(r_depth);
    assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));

    // Register file write port.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(REG_SLOTS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Read ports, optionally forwarding the in-flight write.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            o_rd_data[i*DATA_W +: DATA_W] = r_regs[i_rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (i_wr_en && w_wr_ok && (i_wr_addr == i_rd_addr[i*ADDR_W +: ADDR_W])) begin
                o_rd_data[i*DATA_W +: DATA_W] = i_wr_data;
            end
`endif
        end
    end

    // Exception stack push/pop and privilege mode; push has priority over iret.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(STK_SLOTS); i++) begin
                r_stk_pc[i]   <= '0;
                r_stk_addr[i] <= '0;
                r_stk_type[i] <= '0;
                r_stk_priv[i] <= 1'b0;
            end
            r_depth    <= '0;
            r_priv     <= 1'b1;
            r_overflow <= 1'b0;
        end else if (i_xcpt_valid) begin
            r_stk_pc[w_push_idx]   <= i_xcpt_pc;
            r_stk_addr[w_push_idx] <= i_xcpt_addr;
            r_stk_type[w_push_idx] <= i_xcpt_type;
            r_stk_priv[w_push_idx] <= r_priv;
            r_priv                 <= 1'b1;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_depth <= r_depth + DEPTH_W'(1);
            end
        end else if (i_iret_instr) begin
            if (w_empty) begin
                // iret with nothing saved drops to User mode (boot path).
                r_priv <= 1'b0;
            end else begin
                r_priv  <= r_stk_priv[w_top_idx];
                r_depth <= r_depth - DEPTH_W'(1);
            end
        end
    end

    // Top-of-stack view; all zero when the stack is empty.
    always_comb begin
        o_rm0_data = '0;
        o_rm1_data = '0;
        o_rm2_data = '0;
        if (!w_empty) begin
            o_rm0_data = r_stk_pc[w_top_idx];
            o_rm1_data = r_stk_addr[w_top_idx];
            o_rm2_data = r_stk_type[w_top_idx];
        end
    end

    assign o_priv_mode     = r_priv;
    assign o_xcpt_depth    = r_depth;
    assign o_xcpt_overflow = r_overflow;

endmodule

// File: tb/tb_regfile_xcpt_stack.sv
// Testbench for regfile_xcpt_stack: table of directed vectors plus hand-written
// sequences for reset, same-cycle read/write and reset during operation.
module tb_regfile_xcpt_stack;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned DEPTH_W = 3;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     xv;
    logic [TYPE_W-1:0]        xtype;
    logic [31:0]              xpc;
    logic [31:0]              xaddr;
    logic                     iret;
    logic [31:0]              rm0;
    logic [31:0]              rm1;
    logic [TYPE_W-1:0]        rm2;
    logic                     priv;
    logic [DEPTH_W-1:0]       depth;
    logic                     ovf;

    int errors = 0;
    int checks = 0;

    regfile_xcpt_stack dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .i_wr_en         (wr_en),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .i_xcpt_valid    (xv),
        .i_xcpt_type     (xtype),
        .i_xcpt_pc       (xpc),
        .i_xcpt_addr     (xaddr),
        .i_iret_instr    (iret),
        .o_rm0_data      (rm0),
        .o_rm1_data      (rm1),
        .o_rm2_data      (rm2),
        .o_priv_mode     (priv),
        .o_xcpt_depth    (depth),
        .o_xcpt_overflow (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        xv;
        logic [2:0]  xtype;
        logic [31:0] xpc;
        logic [31:0] xaddr;
        logic        iret;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [31:0] e_rm0;
        logic [31:0] e_rm1;
        logic [2:0]  e_rm2;
        logic        e_priv;
        logic [2:0]  e_depth;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic x, input logic [2:0] xt, input logic [31:0] pc,
                       input logic [31:0] xa, input logic ir,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] m0, input logic [31:0] m1, input logic [2:0] m2,
                       input logic p, input logic [2:0] dp, input logic ov);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa; v.wr_data = wd;
        v.xv = x;      v.xtype = xt;   v.xpc = pc;    v.xaddr = xa;  v.iret = ir;
        v.ra0 = a0;    v.ra1 = a1;
        v.e_rd0 = d0;  v.e_rd1 = d1;   v.e_rm0 = m0;  v.e_rm1 = m1;  v.e_rm2 = m2;
        v.e_priv = p;  v.e_depth = dp; v.e_ovf = ov;
        tbl.push_back(v);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        xv = 1'b0; xtype = '0; xpc = '0; xaddr = '0; iret = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                             input logic [2:0] m2, input logic p, input logic [2:0] dp,
                             input logic ov);
        chk({tag, ".rm0"}, rm0, m0);
        chk({tag, ".rm1"}, rm1, m1);
        chk({tag, ".rm2"}, 32'(rm2), 32'(m2));
        chk({tag, ".priv"}, 32'(priv), 32'(p));
        chk({tag, ".depth"}, 32'(depth), 32'(dp));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ov));
    endtask

    logic [31:0] same_cycle_exp;

    initial begin
        // r3 = DEADBEEF is written by the hand sequence before the table runs.
        //   we wa  wd          xv ty pc      addr    ir a0  a1  rd0         rd1         rm0     rm1     rm2 p dp ov
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        0,      0,      0, 0, 0, 0);
        add(0, 0,  0,          1, 3, 32'h100, 32'h2000, 0, 3, 0, 32'hDEADBEEF, 0,      32'h100, 32'h2000, 3, 1, 1, 0);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        0,      0,      0, 0, 0, 0);
        add(0, 0,  0,          1, 1, 32'h10, 0,      0, 3,  0,  32'hDEADBEEF, 0,        32'h10, 0,      1, 1, 1, 0);
        add(0, 0,  0,          1, 2, 32'h20, 4,      0, 3,  0,  32'hDEADBEEF, 0,        32'h20, 4,      2, 1, 2, 0);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        32'h10, 0,      1, 1, 1, 0);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        0,      0,      0, 0, 0, 0);
        // Five pushes into a four-deep stack; the fifth overwrites the top.
        for (int k = 1; k <= 5; k++) begin
            add(0, 0, 0, 1, 3'(k), 32'(k), 32'(k * 16), 0, 3, 0, 32'hDEADBEEF, 0,
                32'(k), 32'(k * 16), 3'(k), 1, 3'((k > 4) ? 4 : k), (k == 5));
        end
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        3,      32'h30, 3, 1, 3, 1);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        2,      32'h20, 2, 1, 2, 1);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        1,      32'h10, 1, 1, 1, 1);
        add(0, 0,  0,          0, 0, 0,      0,      1, 3,  0,  32'hDEADBEEF, 0,        0,      0,      0, 0, 0, 1);
        // Push + iret + write in one cycle: push wins, write still lands.
        add(1, 7,  32'h55,     1, 6, 32'h40, 32'h80, 1, 7,  3,  32'h55, 32'hDEADBEEF,  32'h40, 32'h80, 6, 1, 1, 1);
        // r0 is an ordinary writable register.
        add(1, 0,  32'h1234,   0, 0, 0,      0,      0, 0,  7,  32'h1234, 32'h55,       32'h40, 32'h80, 6, 1, 1, 1);
        // Write alongside a pop; restored priv is the User mode saved at push.
        add(1, 31, 32'hA5A5,   0, 0, 0,      0,      1, 31, 0,  32'hA5A5, 32'h1234,     0,      0,      0, 0, 0, 1);

        idle();
        rd_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_addr = {5'd31, 5'd0};
        #1;
        chk("reset.rd0", rd_data[31:0], 0);
        chk("reset.rd1", rd_data[63:32], 0);
        chk_state("reset", 0, 0, 0, 1, 0, 0);

        // Same-cycle visibility of a write, then visibility on every port next cycle.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd3, 5'd3};
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'hDEADBEEF;
`else
        same_cycle_exp = 32'h0;
`endif
        #1;
        chk("samecyc.rd0", rd_data[31:0], same_cycle_exp);
        chk("samecyc.rd1", rd_data[63:32], same_cycle_exp);
        @(posedge clk);
        #1 idle();
        #1;
        chk("nextcyc.rd0", rd_data[31:0], 32'hDEADBEEF);
        chk("nextcyc.rd1", rd_data[63:32], 32'hDEADBEEF);

        foreach (tbl[i]) begin
            @(negedge clk);
            wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
            xv = tbl[i].xv; xtype = tbl[i].xtype; xpc = tbl[i].xpc; xaddr = tbl[i].xaddr;
            iret = tbl[i].iret;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            @(posedge clk);
            #1 idle();
            #1;
            chk($sformatf("vec%0d.rd0", i), rd_data[31:0], tbl[i].e_rd0);
            chk($sformatf("vec%0d.rd1", i), rd_data[63:32], tbl[i].e_rd1);
            chk_state($sformatf("vec%0d", i), tbl[i].e_rm0, tbl[i].e_rm1, tbl[i].e_rm2,
                      tbl[i].e_priv, tbl[i].e_depth, tbl[i].e_ovf);
        end

        // Reset while a push and a write are requested: reset wins everything.
        @(negedge clk);
        rst = 1'b1;
        xv = 1'b1; xpc = 32'h77; xtype = 3'd5;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        @(posedge clk);
        #1 idle();
        rst = 1'b0;
        rd_addr = {5'd9, 5'd3};
        #1;
        chk("midrst.rd0", rd_data[31:0], 0);
        chk("midrst.rd1", rd_data[63:32], 0);
        chk_state("midrst", 0, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
